axis_pixels_arb: RTL and testbench

AXIS_PIXELS_ARB -- requirements
Module: axis_pixels_arb

---
 rtl/axis_pixels_arb.sv | 131 +++++++++++++
 tb/tb_axis_pixels_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixels_arb.sv
// axis_pixels_arb: packet-locked round-robin arbiter merging N_SRC AXI-Stream pixel sources
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_valid/s_ready/s_last per-source handshake and end of packet (N_SRC bits each)
//   s_data, s_keep         per-source beat payload, source i at slice [i*W +: W]
//   m_valid/m_ready/m_last merged output handshake and end of packet
//   m_data, m_keep, m_src  merged beat payload and index of the source that produced it
//   pkt_count              completed packets per source, 32 bits each
// Define PIXELS_ARB_PKTCNT_EN to build the packet counters; otherwise pkt_count is 0.
module axis_pixels_arb #(
  parameter int N_SRC = 2,
  parameter int WORD_WIDTH = 8,
  parameter int BYTES = 8
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_SRC-1:0]                    s_valid,
  output logic [N_SRC-1:0]                    s_ready,
  input  logic [N_SRC-1:0]                    s_last,
  input  logic [N_SRC*BYTES*WORD_WIDTH-1:0]   s_data,
  input  logic [N_SRC*BYTES-1:0]              s_keep,
  input  logic                                m_ready,
  output logic                                m_valid,
  output logic                                m_last,
  output logic [BYTES*WORD_WIDTH-1:0]         m_data,
  output logic [BYTES-1:0]                    m_keep,
  output logic [$clog2(N_SRC)-1:0]            m_src,
  output logic [N_SRC*32-1:0]                 pkt_count
);
  localparam int DW = BYTES * WORD_WIDTH;
  localparam int SW = $clog2(N_SRC);
  localparam int BW = 1 + SW + BYTES + DW;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] grant_q, grant_d, ptr_q, ptr_d, win, rr_idx;
  logic [SW:0] rr_sum;
  logic any_v, push, pop;
  logic [DW-1:0] src_data [N_SRC];
  logic [BYTES-1:0] src_keep [N_SRC];
  logic [BW-1:0] in_beat, out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_data[g] = s_data[g*DW +: DW];
    assign src_keep[g] = s_keep[g*BYTES +: BYTES];
  end
  // Scan from the farthest offset down so the nearest valid source after ptr wins.
  always_comb begin
    win = ptr_q;
    any_v = 1'b0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      rr_sum = {1'b0, ptr_q} + (SW+1)'(i);
      rr_idx = rr_sum >= (SW+1)'(N_SRC) ? SW'(rr_sum - (SW+1)'(N_SRC)) : SW'(rr_sum);
      if (s_valid[rr_idx]) begin
        win = rr_idx;
        any_v = 1'b1;
      end
    end
  end
  // The granted source may push only while the skid entry is free.
  assign push = state_q == BUSY && s_valid[grant_q] && !skid_v_q;
  assign pop = out_v_q && m_ready;
  assign in_beat = {s_last[grant_q], grant_q, src_keep[grant_q], src_data[grant_q]};
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    s_ready = '0;
    if (state_q == IDLE) begin
      if (any_v) begin
        state_d = BUSY;
        grant_d = win;
        ptr_d = win;
      end
    end else begin
      s_ready[grant_q] = !skid_v_q;
      if (push && s_last[grant_q]) state_d = IDLE;
    end
  end
  // Output register refills from the skid entry first, so beat order is preserved.
  always_comb begin
    out_v_d = out_v_q;
    out_d = out_q;
    skid_v_d = skid_v_q;
    skid_d = skid_q;
    if (!out_v_q || pop) begin
      out_v_d = skid_v_q || push;
      out_d = skid_v_q ? skid_q : push ? in_beat : out_q;
      skid_v_d = 1'b0;
    end else if (push) begin
      skid_v_d = 1'b1;
      skid_d = in_beat;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= SW'(N_SRC - 1);
      out_v_q <= 1'b0;
      out_q <= '0;
      skid_v_q <= 1'b0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      out_v_q <= out_v_d;
      out_q <= out_d;
      skid_v_q <= skid_v_d;
      skid_q <= skid_d;
    end
  end
  assign m_valid = out_v_q;
  assign {m_last, m_src, m_keep, m_data} = out_q;
`ifdef PIXELS_ARB_PKTCNT_EN
  logic [N_SRC-1:0][31:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (pop && m_last) cnt_d[m_src] = cnt_q[m_src] + 32'd1;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign pkt_count = cnt_q;
`else
  assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_axis_pixels_arb.sv
// tb_axis_pixels_arb: scoreboard bench for axis_pixels_arb
module tb_axis_pixels_arb;
  localparam int N = 2;
  localparam int WW = 8;
  localparam int BY = 8;
  localparam int DW = WW * BY;
  typedef struct {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic last;
    int src;
  } beat_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [N-1:0] s_valid = '0, s_ready, s_last = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N*BY-1:0] s_keep = '0;
  logic m_ready = 1'b1, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [BY-1:0] m_keep;
  logic [$clog2(N)-1:0] m_src;
  logic [N*32-1:0] pkt_count;
  beat_t src_q [N][$];
  beat_t exp_q [$];
  beat_t e;
  logic [N-1:0] hold = '0;
  bit rand_mr = 0;
  int checks = 0, errors = 0;
  logic [N-1:0] obs_sready, obs_acc;
  logic obs_mv, obs_ml;
  logic [$clog2(N)-1:0] obs_ms;
  logic [DW-1:0] pd;
  logic [BY-1:0] pk;
  logic pl, pstall = 0, locked = 0;
  logic [$clog2(N)-1:0] ps;
  int lock_src = 0;

  axis_pixels_arb dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data), .s_keep(s_keep),
    .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_keep(m_keep),
    .m_src(m_src), .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  // Output monitor: pops the scoreboard on every delivered beat, checks stall hold and lock.
  always @(negedge aclk) begin
    if (!aresetn) begin
      pstall = 0;
      locked = 0;
    end else begin
      if (pstall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_keep !== pk || m_last !== pl || m_src !== ps) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b s=%0d, need v=1 d=%h k=%h l=%b s=%0d",
                   m_valid, m_data, m_keep, m_last, m_src, pd, pk, pl, ps);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got beat s=%0d d=%h, need no beat", m_src, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last || m_src !== 1'(e.src)) begin
            errors++;
            $display("FAIL sb_beat: got d=%h k=%h l=%b s=%0d, need d=%h k=%h l=%b s=%0d",
                     m_data, m_keep, m_last, m_src, e.data, e.keep, e.last, e.src);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          checks++;
          if (locked && lock_src != i) begin
            errors++;
            $display("FAIL pkt_lock: got accept from src %0d, need src %0d", i, lock_src);
          end
          locked = !s_last[i];
          lock_src = i;
        end
      end
      checks++;
      if ($countones(s_ready) > 1) begin
        errors++;
        $display("FAIL one_ready: got s_ready=%b, need at most one bit", s_ready);
      end
      pstall = m_valid && !m_ready;
      pd = m_data;
      pk = m_keep;
      pl = m_last;
      ps = m_src;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic add_pkt(input int s, input int n, input int zk);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = (k == zk) ? '0 : BY'($urandom_range(1, 255));
      b.last = (k == n - 1);
      b.src = s;
      src_q[s].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = src_q[i][0].data;
        s_keep[i*BY +: BY] = src_q[i][0].keep;
        s_last[i] = src_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = {$urandom, $urandom};
        s_keep[i*BY +: BY] = BY'($urandom);
        s_last[i] = 1'($urandom);
      end
    end
    m_ready = rand_mr ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: observe at the falling edge, record accepted beats, drive after the rising edge.
  task automatic tick();
    @(negedge aclk);
    obs_sready = s_ready;
    obs_mv = m_valid;
    obs_ml = m_last;
    obs_ms = m_src;
    obs_acc = s_valid & s_ready;
    for (int i = 0; i < N; i++)
      if (obs_acc[i]) exp_q.push_back(src_q[i].pop_front());
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    add_pkt(0, 1, -1);
    drive();
    repeat (2) @(negedge aclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b, need 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b, need 0", m_last); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %h, need 0", m_data); end
    checks++; if (m_keep !== '0) begin errors++; $display("FAIL rst_m_keep: got %h, need 0", m_keep); end
    checks++; if (m_src !== '0) begin errors++; $display("FAIL rst_m_src: got %0d, need 0", m_src); end
    checks++; if (s_ready !== '0) begin errors++; $display("FAIL rst_s_ready: got %b, need 0", s_ready); end
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rst_pkt_count: got %h, need 0", pkt_count); end
    src_q[0].delete();
    drive();
    #2 aresetn = 1'b1;
  endtask

  task automatic test_rr_order();
    logic [6:0] emv, ems;
    bit got, ok;
    emv = 7'b1110111;
    ems = 7'b0000111;
    add_pkt(0, 3, -1);
    add_pkt(1, 3, -1);
    drive();
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      got = obs_mv;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rr_start: got no m_valid, need m_valid within 20 cycles"); end
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs_mv !== emv[6-k] || (emv[6-k] && obs_ms !== ems[6-k])) begin
        errors++;
        $display("FAIL rr_order[%0d]: got v=%b s=%0d, need v=%b s=%0d", k, obs_mv, obs_ms, emv[6-k], ems[6-k]);
      end
    end
    run_until_done(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: got pending beats, need all delivered"); end
  endtask

  task automatic test_lock();
    bit ok;
    int sz;
    add_pkt(1, 6, -1);
    drive();
    for (int t = 0; t < 20 && src_q[1].size() > 4; t++) tick();
    checks++;
    if (src_q[1].size() != 4) begin errors++; $display("FAIL lock_start: got %0d left, need 4", src_q[1].size()); end
    add_pkt(0, 3, -1);
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs_sready[0] !== 1'b0) begin errors++; $display("FAIL lock_hold[%0d]: got s_ready[0]=%b, need 0", k, obs_sready[0]); end
    end
    hold[1] = 1'b0;
    drive();
    for (int t = 0; t < 30 && src_q[1].size() > 0; t++) begin
      sz = src_q[1].size();
      tick();
      if (sz > 0) begin
        checks++;
        if (obs_sready[0] !== 1'b0) begin errors++; $display("FAIL lock_tail: got s_ready[0]=%b, need 0", obs_sready[0]); end
      end
    end
    run_until_done(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lock_drain: got pending beats, need all delivered"); end
  endtask

  task automatic test_stream();
    logic [16:0] mv, ml;
    bit ok;
    add_pkt(0, 16, -1);
    drive();
    obs_acc = '0;
    for (int t = 0; t < 20 && !obs_acc[0]; t++) tick();
    for (int k = 0; k <= 16; k++) begin
      tick();
      mv[k] = obs_mv;
      ml[k] = obs_ml & obs_mv;
    end
    checks++;
    if (mv[0] !== 1'b1) begin errors++; $display("FAIL stream_latency: got m_valid=%b one cycle after accept, need 1", mv[0]); end
    checks++;
    if ($countones(mv[15:0]) != 16) begin errors++; $display("FAIL stream_rate: got %0d valid cycles, need 16", $countones(mv[15:0])); end
    checks++;
    if (ml !== 17'h08000) begin errors++; $display("FAIL stream_last: got last pattern %h, need 08000", ml); end
    checks++;
    if (mv[16] !== 1'b0) begin errors++; $display("FAIL stream_end: got m_valid=%b after packet, need 0", mv[16]); end
    run_until_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_drain: got pending beats, need all delivered"); end
  endtask

  task automatic test_random();
    bit ok;
    rand_mr = 1;
    add_pkt(0, 3, 1);
    add_pkt(1, 1, -1);
    add_pkt(1, 4, 3);
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, $urandom_range(1, 6), -1);
      add_pkt(1, $urandom_range(1, 6), -1);
    end
    drive();
    run_until_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random_drain: got %0d/%0d/%0d pending, need 0/0/0", src_q[0].size(), src_q[1].size(), exp_q.size());
    end
    rand_mr = 0;
    drive();
  endtask

  task automatic test_reset_mid();
    bit got, ok;
    add_pkt(1, 8, -1);
    drive();
    for (int t = 0; t < 20 && src_q[1].size() > 5; t++) tick();
    add_pkt(0, 2, -1);
    drive();
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_data, m_keep, m_src, s_ready} !== '0) begin
      errors++;
      $display("FAIL mid_rst_out: got v=%b l=%b d=%h k=%h s=%0d r=%b, need all 0", m_valid, m_last, m_data, m_keep, m_src, s_ready);
    end
    checks++;
    if (pkt_count !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %h, need 0", pkt_count); end
    src_q[1].delete();
    exp_q.delete();
    add_pkt(1, 2, -1);
    drive();
    @(negedge aclk);
    #2 aresetn = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      got = obs_mv;
    end
    checks++;
    if (!got || obs_ms !== 1'b0) begin errors++; $display("FAIL mid_rst_first: got v=%b s=%0d, need v=1 s=0", got, obs_ms); end
    run_until_done(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_rst_drain: got pending beats, need all delivered"); end
  endtask

  task automatic test_pktcnt();
    bit ok;
    logic [31:0] e0, e1;
    @(negedge aclk);
    aresetn = 1'b0;
    #2 aresetn = 1'b1;
    for (int p = 0; p < 5; p++) add_pkt(0, 1 + p % 2, -1);
    for (int p = 0; p < 3; p++) add_pkt(1, 2 - p % 2, -1);
    drive();
    run_until_done(200, ok);
    tick();
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL cnt_drain: got pending beats, need all delivered"); end
`ifdef PIXELS_ARB_PKTCNT_EN
    e0 = 32'd5;
    e1 = 32'd3;
`else
    e0 = 32'd0;
    e1 = 32'd0;
`endif
    checks++;
    if (pkt_count[31:0] !== e0) begin errors++; $display("FAIL cnt_src0: got %0d, need %0d", pkt_count[31:0], e0); end
    checks++;
    if (pkt_count[63:32] !== e1) begin errors++; $display("FAIL cnt_src1: got %0d, need %0d", pkt_count[63:32], e1); end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_lock();
    test_stream();
    test_random();
    test_reset_mid();
    test_pktcnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
